// File: rtl/mult_pkg.sv
// Shared constants and types for the MIPS multicycle HI/LO units (Booth multiplier and iterative divider).
package mult_pkg;
    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITER  = 32;

    // Booth recoding of {q[0], q_1}; the other two codes leave the accumulator alone.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;
endpackage

// File: rtl/booth_multiplier_if.sv
// Control-unit <-> multiplier bundle: start/operands in, HI/LO words and status out.
interface booth_multiplier_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic             mult_start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output mult_start, multiplicand, multiplier,
        input  hi, lo, busy, done
    );

    modport slave (
        input  mult_start, multiplicand, multiplier,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of m, then arithmetic right shift of {acc, q, q_1}.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q_1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q_1
);
    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum = i_acc;
        case ({i_q[0], i_q_1})
            BOOTH_ADD: w_sum = i_acc + i_m;
            BOOTH_SUB: w_sum = i_acc - i_m;
            default:   w_sum = i_acc;
        endcase
    end

    // The accumulator MSB is replicated so the shift stays arithmetic.
    assign o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_q   = {w_sum[0], i_q[WIDTH-1:1]};
    assign o_q_1 = i_q[0];
endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed WIDTH x WIDTH radix-2 Booth multiplier writing the HI/LO pair.
module booth_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int ITER  = MULT_ITER
) (
    input logic               clk,
    input logic               reset,
    booth_multiplier_if.slave bus
);
    localparam int CW = $clog2(ITER) + 1;

    mult_state_t      r_state, w_next;
    logic [WIDTH:0]   r_acc, r_m, w_acc;
    logic [WIDTH-1:0] r_q, w_q;
    logic             r_q_1, w_q_1;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic             w_load, w_last, w_busy, w_done;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_q_1 (r_q_1),
        .i_m   (r_m),
        .o_acc (w_acc),
        .o_q   (w_q),
        .o_q_1 (w_q_1)
    );

    // Starts are only honoured from IDLE or DONE; a start during RUN is dropped.
    assign w_load = bus.mult_start && (r_state != RUN);
    assign w_last = (r_state == RUN) && (r_count == CW'(ITER - 1));

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: if (bus.mult_start) w_next = RUN;
            RUN: begin
                w_busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = bus.mult_start ? RUN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_q_1   <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_m     <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
                r_q     <= bus.multiplier;
                r_acc   <= '0;
                r_q_1   <= 1'b0;
                r_count <= '0;
            end else if (r_state == RUN) begin
                r_acc   <= w_acc;
                r_q     <= w_q;
                r_q_1   <= w_q_1;
                r_count <= r_count + 1'b1;
                // Capture from the post-shift values so HI/LO are valid on entry to DONE.
                if (w_last) begin
                    r_hi <= w_acc[WIDTH-1:0];
                    r_lo <= w_q;
                end
            end
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = w_busy;
    assign bus.done = w_done;
endmodule

// File: tb/tb_booth_multiplier.sv
// Directed + scoreboard bench for booth_multiplier: latency, corner products, back-to-back, ignored start, reset abort.
module tb_booth_multiplier;
    import mult_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] sbq[$];

    booth_multiplier_if #(.WIDTH(32)) bus ();

    booth_multiplier dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint pa, pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    // Drives a one-cycle start; returns in cycle 1 of the operation.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input bit push, input logic [63:0] exp);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.mult_start   = 1'b1;
        if (push) sbq.push_back(exp);
        tick();
        bus.mult_start   = 1'b0;
    endtask

    // Waits (bounded) for done starting from cycle n0; checks latency, busy, and scoreboard result.
    task automatic wait_done(input string tag, input int n0);
        int   n;
        logic busy_bad;
        logic [63:0] exp;
        n = n0;
        busy_bad = 1'b0;
        while (bus.done !== 1'b1 && n < 40) begin
            if (bus.busy !== 1'b1) busy_bad = 1'b1;
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd33);
        chk({tag, "_busy_run"}, {63'd0, busy_bad}, 64'd0);
        chk({tag, "_busy_in_done"}, {63'd0, bus.busy}, 64'd0);
        exp = (sbq.size() != 0) ? sbq.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        chk({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
    endtask

    initial begin
        logic saw_done;
        logic [31:0] ra, rb;
        reset = 1'b1;
        bus.mult_start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        tick();
        tick();
        chk("reset_outputs", {bus.hi, bus.lo}, 64'd0);
        chk("reset_status", {62'd0, bus.busy, bus.done}, 64'd0);
        reset = 1'b0;
        tick();

        // 3 x 5 with hold afterwards
        start_op(32'd3, 32'd5, 1'b1, 64'h0000_0000_0000_000F);
        wait_done("3x5", 1);
        tick();
        chk("3x5_done_pulse", {63'd0, bus.done}, 64'd0);
        repeat (3) tick();
        chk("3x5_hold", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
        wait_done("m1xm1", 1);
        tick();

        start_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        wait_done("minxmin", 1);
        tick();

        // Back-to-back: second start lands in the DONE cycle of the first
        start_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0001);
        wait_done("maxxm1", 1);
        start_op(32'h0001_0000, 32'h0001_0000, 1'b1, 64'h0000_0001_0000_0000);
        wait_done("b2b", 1);
        tick();

        // Start and operand changes during RUN must be ignored
        start_op(32'd7, 32'd9, 1'b1, 64'h0000_0000_0000_003F);
        repeat (9) tick();
        bus.multiplicand = 32'd100;
        bus.multiplier   = 32'd200;
        bus.mult_start   = 1'b1;
        tick();
        bus.mult_start   = 1'b0;
        repeat (4) tick();
        bus.multiplicand = 32'hDEAD_BEEF;
        bus.multiplier   = 32'h1234_5678;
        wait_done("ignore_start", 15);
        tick();

        for (int i = 0; i < 4; i++) begin
            ra = $urandom();
            rb = $urandom();
            start_op(ra, rb, 1'b1, model(ra, rb));
            wait_done("random", 1);
            tick();
        end

        // Mid-RUN reset after a non-zero result is held
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
        wait_done("pre_reset", 1);
        tick();
        start_op(32'd12345, 32'd678, 1'b0, 64'd0);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_status", {62'd0, bus.busy, bus.done}, 64'd0);
        chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("abort_state", {62'd0, dut.r_state}, {62'd0, IDLE});
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
            tick();
        end
        chk("abort_no_done", {63'd0, saw_done}, 64'd0);
        start_op(32'd12345, 32'd678, 1'b1, 64'h0000_0000_007F_B6F6);
        wait_done("after_reset", 1);
        tick();

        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
